// File: rtl/sstv_vis_rx.sv
// sstv_vis_rx: VIS header receiver (start tone, LSB-first data, optional parity, stop tone)
module sstv_vis_rx #(
  parameter int CLK_TICKS_BIT = 3000000,
  parameter int FREQ_W        = 12,
  parameter int DATA_BITS     = 7,
  parameter int PARITY_MODE   = 0,
  parameter int FREQ_TOL      = 0,
  parameter int F_SYNC        = 1200,
  parameter int F_ONE         = 1100,
  parameter int F_ZERO        = 1300
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FREQ_W-1:0]    freq,
  input  logic                 cal_ok,
  output logic [DATA_BITS-1:0] vis_code,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(CLK_TICKS_BIT + 1);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] TICKS = CW'(CLK_TICKS_BIT);
  localparam logic [CW-1:0] HALF  = CW'(CLK_TICKS_BIT / 2);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [NW-1:0] NBITS = NW'(DATA_BITS);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    START = 6'b000010,
    DATA  = 6'b000100,
    PAR   = 6'b001000,
    STOP  = 6'b010000,
    DONE  = 6'b100000
  } state_t;

  function automatic logic match(input logic [FREQ_W-1:0] f, input int c);
    logic [FREQ_W:0] lo, hi;
    lo = (c >= FREQ_TOL) ? (FREQ_W+1)'(c - FREQ_TOL) : '0;
    hi = (FREQ_W+1)'(c + FREQ_TOL);
    return ({1'b0, f} >= lo) && ({1'b0, f} <= hi);
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NW-1:0]        nb_q, nb_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, code_q, code_d;
  logic                 par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 m_sync, m_one, m_zero, samp, bnd, abort, ok;

  assign m_sync = match(freq, F_SYNC);
  assign m_one  = match(freq, F_ONE);
  assign m_zero = match(freq, F_ZERO);
  assign samp   = cnt_q == HALF;
  assign bnd    = cnt_q == TICKS;
  assign ok     = (PARITY_MODE == 2) ? 1'b1 : (PARITY_MODE == 1) ? (^sh_q ^ par_q) : !(^sh_q ^ par_q);

  // next-state, bit timing, shifting and result latching
  always_comb begin
    state_d = state_q;
    cnt_d   = bnd ? ONE : cnt_q + ONE;
    nb_d    = nb_q;
    sh_d    = sh_q;
    par_d   = par_q;
    code_d  = code_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = ONE;
        nb_d  = '0;
        if (m_sync) begin
          state_d = START;
          valid_d = 1'b0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (samp && !m_sync) abort = 1'b1;
        else if (bnd) state_d = DATA;
      end
      DATA: begin
        if (samp) begin
          if (m_one || m_zero) begin
            sh_d = DATA_BITS'({m_one, sh_q} >> 1);
            nb_d = nb_q + NW'(1);
          end else abort = 1'b1;
        end else if (bnd && nb_q == NBITS) state_d = (PARITY_MODE == 2) ? STOP : PAR;
      end
      PAR: begin
        if (samp) begin
          if (m_one || m_zero) par_d = m_one;
          else abort = 1'b1;
        end else if (bnd) state_d = STOP;
      end
      STOP: begin
        if (samp && !m_sync) abort = 1'b1;
        else if (bnd) begin
          state_d = DONE;
          code_d  = ok ? sh_q : code_q;
          valid_d = ok;
          perr_d  = !ok;
        end
      end
      DONE: cnt_d = ONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = ONE;
      ferr_d  = 1'b1;
    end
    if (!cal_ok) begin
      state_d = IDLE;
      cnt_d   = ONE;
      nb_d    = '0;
      sh_d    = '0;
      par_d   = 1'b0;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // state and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= ONE;
      nb_q    <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign vis_code   = code_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = !(state_q == IDLE || state_q == DONE);

  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot(state_q));
  a_known:  assert property (@(posedge clk) disable iff (!reset_n) !$isunknown({freq, cal_ok}));
  a_excl:   assert property (@(posedge clk) disable iff (!reset_n) !(valid_q && perr_q));
endmodule

// File: tb/tb_sstv_vis_rx.sv
// tb_sstv_vis_rx: scoreboard bench for three sstv_vis_rx configurations
module tb_sstv_vis_rx;
  localparam int TB = 100;

  typedef struct {
    int         inst;
    logic       v, p, f;
    logic [7:0] code;
    int         at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] freq = '0;
  logic        cal_ok = 1'b0;
  int          sel = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  logic       cal[3];
  logic       va[3], pe[3], fe[3], bz[3];
  logic [6:0] c0, c1;
  logic [7:0] c2;
  logic [7:0] vc[3];

  assign cal[0] = cal_ok && sel == 0;
  assign cal[1] = cal_ok && sel == 1;
  assign cal[2] = cal_ok && sel == 2;
  assign vc[0]  = {1'b0, c0};
  assign vc[1]  = {1'b0, c1};
  assign vc[2]  = c2;

  sstv_vis_rx #(.CLK_TICKS_BIT(TB), .FREQ_TOL(0)) u0 (
    .clk(clk), .reset_n(rst_n), .freq(freq), .cal_ok(cal[0]), .vis_code(c0),
    .valid(va[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));
  sstv_vis_rx #(.CLK_TICKS_BIT(TB), .FREQ_TOL(20)) u1 (
    .clk(clk), .reset_n(rst_n), .freq(freq), .cal_ok(cal[1]), .vis_code(c1),
    .valid(va[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));
  sstv_vis_rx #(.CLK_TICKS_BIT(TB), .DATA_BITS(8), .PARITY_MODE(2)) u2 (
    .clk(clk), .reset_n(rst_n), .freq(freq), .cal_ok(cal[2]), .vis_code(c2),
    .valid(va[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int inst, input logic v, input logic p, input logic f, input logic [7:0] code, input int dly);
    exp_t e;
    e.inst = inst; e.v = v; e.p = p; e.f = f; e.code = code; e.at = cyc + 1 + dly;
    sb.push_back(e);
  endtask

  // drive len bit periods of a frame, one tone per period, starting on a falling edge
  task automatic frame(input logic [7:0] code, input int nb, input bit has_par, input bit par,
                       input int off, input int bad, input int bad_off, input int len);
    int n;
    n = nb + 2 + (has_par ? 1 : 0);
    for (int k = 0; k < len; k++) begin
      int f;
      if (k == 0 || k == n - 1) f = 1200;
      else if (k <= nb) f = code[k-1] ? 1100 : 1300;
      else f = par ? 1100 : 1300;
      freq = 12'(f + ((k == bad) ? bad_off : off));
      repeat (TB) @(negedge clk);
    end
    freq = '0;
  endtask

  // monitor: every completion or abort pops one expected event
  initial begin
    logic pv[3], pp[3];
    exp_t e;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pp[i] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n && (fe[i] || (va[i] && !pv[i]) || (pe[i] && !pp[i]))) begin
          if (sb.size() == 0) chk("unexpected_event_inst", 64'(i), 64'hff);
          else begin
            e = sb.pop_front();
            chk("event_inst_v_p_f_code", {4'(i), va[i], pe[i], fe[i], vc[i]},
                {4'(e.inst), e.v, e.p, e.f, e.code});
            chk("event_cycle", 64'(cyc), 64'(e.at));
          end
        end
        pv[i] = va[i];
        pp[i] = pe[i];
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_outputs", {vc[i], va[i], pe[i], fe[i], bz[i]}, 64'h0);
    rst_n = 1'b1;
    sel = 0;
    cal_ok = 1'b1;
    @(negedge clk);
    // even parity, exact tones, code 2C
    push(0, 1, 0, 0, 8'h2C, 10 * TB);
    frame(8'h2C, 7, 1, 1, 0, -1, 0, 10);
    repeat (5) @(negedge clk);
    chk("done_holds_valid", va[0], 1'b1);
    cal_ok = 1'b0;
    @(negedge clk);
    cal_ok = 1'b1;
    chk("cal_drop_clears_valid", va[0], 1'b0);
    chk("cal_drop_keeps_code", vc[0], 8'h2C);
    // flipped parity bit
    push(0, 0, 1, 0, 8'h2C, 10 * TB);
    frame(8'h2C, 7, 1, 0, 0, -1, 0, 10);
    repeat (2) @(negedge clk);
    cal_ok = 1'b0;
    @(negedge clk);
    chk("cal_drop_clears_perr", pe[0], 1'b0);
    chk("cal_drop_no_ferr", fe[0], 1'b0);
    cal_ok = 1'b1;
    // tolerance 20: +15 Hz decodes, +25 Hz on bit 3 aborts
    sel = 1;
    @(negedge clk);
    push(1, 1, 0, 0, 8'h13, 10 * TB);
    frame(8'h13, 7, 1, 1, 15, -1, 0, 10);
    repeat (2) @(negedge clk);
    cal_ok = 1'b0;
    @(negedge clk);
    cal_ok = 1'b1;
    push(1, 0, 0, 1, 8'h13, 4 * TB + TB / 2);
    frame(8'h13, 7, 1, 1, 15, 4, 25, 5);
    repeat (2) @(negedge clk);
    chk("abort_busy_low", bz[1], 1'b0);
    // short sync glitch then an off-band tone
    sel = 0;
    @(negedge clk);
    push(0, 0, 0, 1, 8'h2C, TB / 2);
    freq = 12'd1200;
    repeat (20) @(negedge clk);
    freq = 12'd1500;
    repeat (TB) @(negedge clk);
    chk("glitch_no_valid", va[0], 1'b0);
    freq = '0;
    // cal_ok drop during data bit 4, then a clean frame
    frame(8'h55, 7, 1, 0, 0, -1, 0, 5);
    freq = 12'd1100;
    repeat (20) @(negedge clk);
    chk("mid_frame_busy", bz[0], 1'b1);
    cal_ok = 1'b0;
    @(negedge clk);
    chk("cal_drop_idle", bz[0], 1'b0);
    chk("cal_drop_no_ferr_mid", fe[0], 1'b0);
    freq = '0;
    cal_ok = 1'b1;
    @(negedge clk);
    push(0, 1, 0, 0, 8'h55, 10 * TB);
    frame(8'h55, 7, 1, 0, 0, -1, 0, 10);
    repeat (2) @(negedge clk);
    // no parity, 8 bits, then async reset during the stop tone
    cal_ok = 1'b0;
    sel = 2;
    @(negedge clk);
    cal_ok = 1'b1;
    @(negedge clk);
    push(2, 1, 0, 0, 8'hA5, 10 * TB);
    frame(8'hA5, 8, 0, 0, 0, -1, 0, 10);
    repeat (3) @(negedge clk);
    chk("noparity_done_holds", va[2], 1'b1);
    cal_ok = 1'b0;
    @(negedge clk);
    cal_ok = 1'b1;
    frame(8'h3C, 8, 0, 0, 0, -1, 0, 9);
    freq = 12'd1200;
    repeat (TB / 2) @(negedge clk);
    chk("stop_busy", bz[2], 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {vc[2], va[2], pe[2], fe[2], bz[2]}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    freq = '0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
